// File: rtl/alu_seq.sv
// ============================================================================
// Module      : alu_seq
// Description : RV32I execution-stage ALU with valid/ready handshakes on both
//               sides; shifts are iterative (1 bit/cycle) unless FAST_SHIFT=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int FAST_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_ctrl,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [3:0] c_ADD  = 4'b0000;
    localparam logic [3:0] c_SUB  = 4'b0001;
    localparam logic [3:0] c_AND  = 4'b0010;
    localparam logic [3:0] c_OR   = 4'b0011;
    localparam logic [3:0] c_XOR  = 4'b0100;
    localparam logic [3:0] c_SLL  = 4'b0101;
    localparam logic [3:0] c_SRL  = 4'b0110;
    localparam logic [3:0] c_SRA  = 4'b0111;
    localparam logic [3:0] c_SLT  = 4'b1000;
    localparam logic [3:0] c_SLTU = 4'b1001;
    localparam logic [3:0] c_PASS = 4'b1010;

    logic [1:0]  r_state;
    logic [31:0] r_result;
    logic [4:0]  r_cnt;
    logic [1:0]  r_shop;

    logic [4:0]  w_shamt;
    logic        w_is_shift;
    logic        w_iterate;
    logic [31:0] w_shift_res;
    logic [31:0] w_alu;
    logic [31:0] w_step;

    assign w_shamt    = op_b[4:0];
    assign w_is_shift = (alu_ctrl == c_SLL) || (alu_ctrl == c_SRL) || (alu_ctrl == c_SRA);

    generate
        if (FAST_SHIFT != 0) begin : g_fast_shift
            always_comb begin
                w_shift_res = op_a;
                case (alu_ctrl)
                    c_SLL:   w_shift_res = op_a << w_shamt;
                    c_SRL:   w_shift_res = op_a >> w_shamt;
                    c_SRA:   w_shift_res = $unsigned($signed(op_a) >>> w_shamt);
                    default: w_shift_res = op_a;
                endcase
            end
            assign w_iterate = 1'b0;
        end else begin : g_iter_shift
            // Only a zero shift finishes in one cycle, and it is just op_a.
            assign w_shift_res = op_a;
            assign w_iterate   = w_is_shift && (w_shamt != 5'd0);
        end
    endgenerate

    always_comb begin
        w_alu = 32'd0;
        case (alu_ctrl)
            c_ADD:  w_alu = op_a + op_b;
            c_SUB:  w_alu = op_a - op_b;
            c_AND:  w_alu = op_a & op_b;
            c_OR:   w_alu = op_a | op_b;
            c_XOR:  w_alu = op_a ^ op_b;
            c_SLL,
            c_SRL,
            c_SRA:  w_alu = w_shift_res;
            c_SLT:  w_alu = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
            c_SLTU: w_alu = (op_a < op_b) ? 32'd1 : 32'd0;
            c_PASS: w_alu = op_b;
            default: w_alu = 32'd0;
        endcase
    end

    // r_shop holds alu_ctrl[1:0]: 01 SLL, 10 SRL, 11 SRA.
    always_comb begin
        w_step = {r_result[31], r_result[31:1]};
        case (r_shop)
            2'b01:   w_step = {r_result[30:0], 1'b0};
            2'b10:   w_step = {1'b0, r_result[31:1]};
            default: w_step = {r_result[31], r_result[31:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_result <= 32'd0;
            r_cnt    <= 5'd0;
            r_shop   <= 2'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        if (w_iterate) begin
                            r_result <= op_a;
                            r_cnt    <= w_shamt;
                            r_shop   <= alu_ctrl[1:0];
                            r_state  <= c_SHIFT;
                        end else begin
                            r_result <= w_alu;
                            r_state  <= c_DONE;
                        end
                    end
                end
                c_SHIFT: begin
                    r_result <= w_step;
                    r_cnt    <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign result    = r_result;
    assign zero      = (r_result == 32'd0);

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module      : tb_alu_seq
// Description : Scoreboard bench for alu_seq, iterative and barrel variants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

    localparam logic [3:0] c_ADD  = 4'b0000;
    localparam logic [3:0] c_SUB  = 4'b0001;
    localparam logic [3:0] c_AND  = 4'b0010;
    localparam logic [3:0] c_OR   = 4'b0011;
    localparam logic [3:0] c_XOR  = 4'b0100;
    localparam logic [3:0] c_SLL  = 4'b0101;
    localparam logic [3:0] c_SRL  = 4'b0110;
    localparam logic [3:0] c_SRA  = 4'b0111;
    localparam logic [3:0] c_SLT  = 4'b1000;
    localparam logic [3:0] c_SLTU = 4'b1001;
    localparam logic [3:0] c_PASS = 4'b1010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, zero;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a, op_b, result;

    logic        f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_zero;
    logic [3:0]  f_alu_ctrl;
    logic [31:0] f_op_a, f_op_b, f_result;

    logic [31:0] q[$];
    logic [31:0] qf[$];
    int          n_checks = 0;
    int          n_err    = 0;

    always #5 clk = ~clk;

    alu_seq #(.FAST_SHIFT(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero)
    );

    alu_seq #(.FAST_SHIFT(1)) u_dut_fast (
        .clk(clk), .rst_n(rst_n),
        .in_valid(f_in_valid), .in_ready(f_in_ready),
        .alu_ctrl(f_alu_ctrl), .op_a(f_op_a), .op_b(f_op_b),
        .out_valid(f_out_valid), .out_ready(f_out_ready),
        .result(f_result), .zero(f_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: one pop per completed handshake.
    logic [31:0] m_exp, mf_exp;
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                m_exp = q.pop_front();
                check("result", result, m_exp);
                check("zero", {31'd0, zero}, {31'd0, (m_exp == 32'd0)});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && f_out_valid && f_out_ready) begin
            if (qf.size() == 0) begin
                check("fast_spurious_out", {31'd0, f_out_valid}, 32'd0);
            end else begin
                mf_exp = qf.pop_front();
                check("fast_result", f_result, mf_exp);
                check("fast_zero", {31'd0, f_zero}, {31'd0, (mf_exp == 32'd0)});
            end
        end
    end

    // Inputs are scrambled and in_valid kept high while busy; none of it may matter.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat, input int hold);
        int n;
        out_ready = (hold == 0);
        alu_ctrl  = c;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        @(posedge clk);
        q.push_back(e);
        #1;
        check("busy_in_ready", {31'd0, in_ready}, 32'd0);
        op_a     = ~a;
        op_b     = {b[31:5], ~b[4:0]};
        alu_ctrl = c ^ 4'b0011;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, lat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", result, e);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic issue_fast(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] e);
        f_alu_ctrl = c;
        f_op_a     = a;
        f_op_b     = b;
        f_in_valid = 1'b1;
        @(posedge clk);
        qf.push_back(e);
        #1;
        f_in_valid = 1'b0;
        check("fast_latency", {31'd0, f_out_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; alu_ctrl = 4'd0; op_a = 32'd0; op_b = 32'd0; out_ready = 1'b1;
        f_in_valid = 1'b0; f_alu_ctrl = 4'd0; f_op_a = 32'd0; f_op_b = 32'd0; f_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue_fast(c_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001);
        issue_fast(c_SRA, 32'h8000_0000, 32'd4,  32'hF800_0000);
        issue_fast(c_SLL, 32'h0000_0001, 32'd4,  32'h0000_0010);

        issue(c_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 0);
        issue(c_SUB,  32'd5,         32'd5,         32'h0000_0000, 1, 0);
        issue(c_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 5, 0);
        issue(c_SLL,  32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1, 0);
        issue(c_SRL,  32'hFFFF_FFFF, 32'd31,        32'h0000_0001, 32, 0);
        issue(c_SLL,  32'h0000_0003, 32'd5,         32'h0000_0060, 6, 0);
        issue(c_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 0);
        issue(c_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0);
        issue(c_PASS, 32'hAAAA_AAAA, 32'h1234_5000, 32'h1234_5000, 1, 0);
        issue(4'b1111, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1, 0);
        issue(4'b1011, 32'h0000_0007, 32'h0000_0003, 32'h0000_0000, 1, 0);
        issue(c_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 0);
        issue(c_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1, 0);
        issue(c_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 0);
        issue(c_ADD,  32'd1,         32'd2,         32'h0000_0003, 1, 10);
        issue(c_SRL,  32'h8000_0000, 32'd3,         32'h1000_0000, 4, 10);

        // Reset in the 7th cycle of a 20-bit shift; the operation must vanish.
        alu_ctrl = c_SLL; op_a = 32'h0000_0001; op_b = 32'd20; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_zero", {31'd0, zero}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(c_SUB, 32'd10, 32'd3, 32'h0000_0007, 1, 0);

        repeat (3) @(posedge clk);
        check("queue_drained", q.size(), 32'd0);
        check("fast_queue_drained", qf.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
